// File: rtl/mux_input_conditioner_if.sv
// mux_input_conditioner_if
//
// This interface groups the standard tile pad bus. The `master` modport is
// the board/pad side and the `slave` modport is the conditioner.
//
//   ui_in   [7:0]  raw pad inputs (select, data i0, data i1, auto request)
//   uo_out  [7:0]  conditioned outputs (sel, i0, i1, sel_chg, auto, count[2:0])
//   uio_in  [7:0]  bidirectional pads, input side (unused by the conditioner)
//   uio_out [7:0]  bidirectional pads, output side (change count when enabled)
//   uio_oe  [7:0]  bidirectional pad output enables
interface mux_input_conditioner_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/mux_input_conditioner.sv
// mux_input_conditioner
//
// This is the input-conditioning stage that sits ahead of the 2:1 mux tile.
// It works as follows:
//   - It synchronizes the raw select, data and auto-request pads.
//   - It debounces the select in MANUAL mode.
//   - In AUTO mode, it toggles the select from a free-running divider.
//   - It emits a one-cycle change strobe the cycle after `sel` changes.
//
// Ports:
//   clk    - single clock; all state updates on the rising edge
//   rst_n  - asynchronous active-low reset (released synchronously to clk)
//   ena    - tile power-good; ignored
//   tile   - tile pad bus (slave side):
//              ui_in[0] raw select, ui_in[1] raw i0, ui_in[2] raw i1,
//              ui_in[3] auto-mode request, ui_in[7:4] unused
//              uo_out[0] sel, [1] i0, [2] i1, [3] sel_chg, [4] auto active,
//              uo_out[7:5] change count bits [2:0]
//              uio_out change count, uio_oe pad enables, uio_in unused
//
// Parameters:
//   DEBOUNCE_CYCLES - stable synchronized cycles needed before sel follows (1..255)
//   AUTO_PERIOD     - clock cycles between auto-mode select toggles (2..2^24)
//
// Optional feature macro:
//   MUXCOND_CNT_EN  - defining this macro enables the 8-bit select change counter.
//                     The counter then drives uio_out and uo_out[7:5], and uio_oe
//                     is set to 8'hFF. When the macro is not defined, these
//                     outputs are all zero.
module mux_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int AUTO_PERIOD     = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    mux_input_conditioner_if.slave  tile
);

    localparam int         DIV_W    = $clog2(AUTO_PERIOD);
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_PERIOD - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [1:0]       data_q;
    logic             sel_q, sel_d;
    logic             sel_prev_q;
    logic             sel_chg_q;
    logic [7:0]       deb_q, deb_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       cnt_bits;

    logic sync_sel;
    logic sync_auto;

    // The pad bits that the conditioner does not use are folded together here
    // so that they are visibly consumed.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, tile.uio_in, tile.ui_in[7:4]};

    assign sync_sel  = sync2_q[0];
    assign sync_auto = sync2_q[3];

    // Two-flop synchronizers on the four live pad inputs. The data bits get
    // one more register, so pad-to-output latency matches the mode path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            data_q  <= '0;
        end else begin
            sync1_q <= tile.ui_in[3:0];
            sync2_q <= sync1_q;
            data_q  <= sync2_q[2:1];
        end
    end

    // State register for the mode FSM, the debounce counter and the divider.
    // The change strobe is formed from sel and its one-cycle-old copy, so it
    // fires the cycle after sel moves, whichever mode moved it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MANUAL;
            sel_q      <= 1'b0;
            sel_prev_q <= 1'b0;
            sel_chg_q  <= 1'b0;
            deb_q      <= '0;
            div_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            sel_prev_q <= sel_q;
            sel_chg_q  <= sel_q ^ sel_prev_q;
            deb_q      <= deb_d;
            div_q      <= div_d;
        end
    end

    // This block holds the next-state logic. Each counter defaults to zero,
    // so it is held cleared in the mode that does not own it. This means
    // entering AUTO starts the divider fresh, and leaving AUTO restarts the
    // debounce from zero. The divider terminal count is evaluated regardless
    // of the mode request, so a toggle that coincides with a mode switch
    // still happens.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        deb_d   = '0;
        div_d   = '0;
        case (state_q)
            MANUAL: begin
                if (sync_sel != sel_q) begin
                    if (deb_q == DEB_LAST) begin
                        sel_d = sync_sel;
                    end else begin
                        deb_d = deb_q + 8'd1;
                    end
                end
                if (sync_auto) begin
                    state_d = AUTO;
                end
            end
            AUTO: begin
                if (div_q == DIV_LAST) begin
                    sel_d = ~sel_q;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
                if (!sync_auto) begin
                    state_d = MANUAL;
                end
            end
            default: begin
                state_d = MANUAL;
            end
        endcase
    end

`ifdef MUXCOND_CNT_EN
    logic [7:0] cnt_q;

    // This counts every sel transition. It wraps naturally from 255 to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (sel_d != sel_q) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign tile.uio_out = cnt_q;
    assign tile.uio_oe  = 8'hFF;
    assign cnt_bits     = cnt_q[2:0];
`else
    assign tile.uio_out = 8'h00;
    assign tile.uio_oe  = 8'h00;
    assign cnt_bits     = 3'b000;
`endif

    assign tile.uo_out = {cnt_bits, (state_q == AUTO), sel_chg_q,
                          data_q[1], data_q[0], sel_q};

endmodule

// File: doc/mux_input_conditioner.md
# mux_input_conditioner

Input-conditioning stage directly upstream of the 2:1 mux tile. Synchronizes the raw pad inputs (select, data 0, data 1), debounces the select, and optionally auto-toggles it from a divider. Drives clean registered `sel`/`i0`/`i1` plus a one-cycle change strobe that the mux stage and the board-level observers consume. Packaged with the standard tile pinout.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized cycles required before `sel` changes. Legal range 1..255.
- `AUTO_PERIOD`, default 1000000: clock cycles between auto-mode select toggles. Legal range 2..2^24.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low; release synchronous to `clk`.
- `ena` input 1: always 1 when powered; ignored.
- `ui_in` input 8: [0] raw select, [1] raw data i0, [2] raw data i1, [3] auto-mode request, [7:4] unused.
- `uo_out` output 8: [0] sel, [1] i0, [2] i1, [3] sel_chg strobe, [4] auto-mode active, [7:5] change count bits [2:0].
- `uio_in` input 8: unused.
- `uio_out` output 8: change count [7:0] (see Configuration).
- `uio_oe` output 8: 8'hFF with counter feature, else 8'h00.

## Operation
- Synchronizers: `ui_in[3:0]` each pass through a 2-flop synchronizer. `i0`/`i1` outputs are the synchronized values registered once more; no debounce.
- FSM, 2 states, transitions evaluated on synchronized `ui_in[3]`:
  - MANUAL: debounce active. Counter increments while sync select != `sel`; clears to 0 when equal. When counter reaches `DEBOUNCE_CYCLES`, `sel` takes the sync value and counter clears. MANUAL -> AUTO when sync auto = 1.
  - AUTO: raw select ignored, debounce counter held at 0. Divider counts 0..`AUTO_PERIOD`-1; on terminal count `sel` inverts and divider wraps to 0. AUTO -> MANUAL when sync auto = 0.
- Entering AUTO clears the divider; leaving AUTO keeps current `sel`, debounce restarts from 0.
- `sel_chg` pulses high exactly one cycle on the cycle after `sel` changes, from either mode.
- Change count: 8-bit, increments on every `sel` change, wraps 255 -> 0.
- Mode switch and divider terminal count on the same edge: the toggle is applied, the mode changes.
- Raw select bouncing within the window: any cycle of equality resets the debounce counter; `sel` unchanged.

## Timing
- Reset values: `sel`=0, `i0`=0, `i1`=0, `sel_chg`=0, auto flag=0, change count=0, FSM=MANUAL, all counters 0, all synchronizer flops 0; `uo_out`=8'h00, `uio_out`=8'h00.
- Reset asserted mid-operation clears all state immediately, independent of `clk`.
- Data latency: `ui_in[1]`/`[2]` change to `uo_out[1]`/`[2]` = 3 rising edges.
- Select latency (MANUAL, clean edge): 2 + `DEBOUNCE_CYCLES` rising edges to `sel`; `sel_chg` one edge later.
- Mode latency: `ui_in[3]` to `uo_out[4]` = 3 rising edges.
- Auto toggle period: exactly `AUTO_PERIOD` cycles between consecutive `sel` changes.

## Configuration
- `MUXCOND_CNT_EN` defined: change count drives `uio_out[7:0]`, `uio_oe`=8'hFF, and `uo_out[7:5]`=count[2:0].
- Undefined: 8-bit counter omitted; `uio_out`=8'h00, `uio_oe`=8'h00, `uo_out[7:5]`=3'b000.

## Test plan
- Reset: assert `rst_n`=0 mid-toggle with `ui_in`=8'hFF -> all outputs 0 immediately; after release with `ui_in`=0, outputs stay 0.
- Debounce, `DEBOUNCE_CYCLES`=4: hold `ui_in[0]`=1 -> `uo_out[0]` rises on edge 6, `uo_out[3]` high on edge 7 only, count = 1.
- Bounce: `ui_in[0]` toggling 1,1,1,0,1,1,1,0 each cycle with `DEBOUNCE_CYCLES`=4 -> `sel` never changes, `sel_chg` never pulses.
- Data path: `ui_in[2:1]`=2'b10 -> `uo_out[2:1]`=2'b10 after 3 edges, `sel` unaffected.
- Auto mode, `AUTO_PERIOD`=5: `ui_in[3]`=1 -> `uo_out[4]`=1 after 3 edges, `sel` toggles every 5 cycles, raw `ui_in[0]` ignored; drop `ui_in[3]` -> `sel` holds last value.
- Wrap (`MUXCOND_CNT_EN`): 256 select changes -> `uio_out` returns to 8'h00, `uio_oe`=8'hFF throughout; without macro `uio_out`=`uio_oe`=8'h00.
